crossbar_line_credit_ctrl: RTL and testbench



---
 rtl/crossbar_line_credit_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_crossbar_line_credit_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_line_credit_ctrl.sv
// crossbar_line_credit_ctrl
// Ingress controller for one line of the 4x4 crossbar fabric. It steers a
// packetised word stream to the column named in the SOP header and holds the
// column from SOP to EOP. Per-column credit counters keep the line's
// cross-node buffers from overflowing; column readers return credits with
// pop pulses.
//
// Optional feature (macro CB_LINE_STATS_EN): adds per-column packet counters,
// a saturating stall-cycle counter and a synchronous clear input.
//
// Handshake: a word transfers on a rising i_clk edge when i_valid and o_ready
// are both high. o_ready depends combinationally on i_valid, i_sop and i_din,
// so the source must not make i_valid depend on o_ready.
//
// o_state exposes the FSM state (0 = IDLE, 1 = XFER) for debug and checkers.

module crossbar_line_credit_ctrl #(
    parameter int DATA_W     = 32,
    parameter int NODE_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
`ifdef CB_LINE_STATS_EN
    input  logic                 i_stats_clr,
    output logic [4*16-1:0]      o_pkt_cnt,
    output logic [15:0]          o_stall_cnt,
`endif
    input  logic [DATA_W-1:0]    i_din,
    input  logic                 i_valid,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 o_ready,
    output logic [DATA_W-1:0]    o_cb_din,
    output logic [1:0]           o_cb_sel,
    output logic                 o_cb_wr_en,
    input  logic [3:0]           i_credit_ret,
    output logic [4*CNT_W-1:0]   o_credit,
    output logic                 o_proto_err,
    output logic                 o_credit_err,
    output logic                 o_state
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NODE_DEPTH);

    state_t           state;
    logic [1:0]       col;
    logic [CNT_W-1:0] credit [4];

    logic [1:0]       hdr_col;
    logic [1:0]       wr_col;
    logic             accept;
    logic             wr_fire;
    logic [3:0]       dec;

    assign hdr_col = i_din[3:2];
    assign accept  = i_valid && o_ready;
    assign o_state = state;

    // Ready: a header needs credit in its own column; a body word needs
    // credit in the held column; stray words in IDLE are always drained.
    always_comb begin
        o_ready = 1'b1;
        if (i_valid && i_sop) begin
            o_ready = (credit[hdr_col] != '0);
        end else if (state == XFER) begin
            o_ready = (credit[col] != '0);
        end
    end

    // Which accepted words go into the fabric, and which column they consume.
    always_comb begin
        wr_fire = accept && (i_sop || (state == XFER));
        wr_col  = i_sop ? hdr_col : col;
        dec     = '0;
        if (wr_fire) begin
            dec[wr_col] = 1'b1;
        end
    end

    // Packet FSM and registered fabric-side outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            col         <= '0;
            o_cb_din    <= '0;
            o_cb_sel    <= '0;
            o_cb_wr_en  <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            o_cb_wr_en  <= 1'b0;
            o_proto_err <= 1'b0;
            if (accept) begin
                if (i_sop) begin
                    // A header mid-packet means the previous EOP went missing;
                    // flag it and restart on the new header.
                    if (state == XFER) begin
                        o_proto_err <= 1'b1;
                    end
                    col        <= hdr_col;
                    o_cb_din   <= i_din;
                    o_cb_sel   <= hdr_col;
                    o_cb_wr_en <= 1'b1;
                    state      <= i_eop ? IDLE : XFER;
                end else if (state == XFER) begin
                    o_cb_din   <= i_din;
                    o_cb_sel   <= col;
                    o_cb_wr_en <= 1'b1;
                    if (i_eop) begin
                        state <= IDLE;
                    end
                end else begin
                    o_proto_err <= 1'b1;
                end
            end
        end
    end

    // Credit counters: minus one per written word, plus one per return,
    // saturating at the buffer depth with a sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < 4; c++) begin
                credit[c] <= FULL;
            end
            o_credit_err <= 1'b0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (i_credit_ret[c] && !dec[c]) begin
                    if (credit[c] >= FULL) begin
                        o_credit_err <= 1'b1;
                    end else begin
                        credit[c] <= credit[c] + 1'b1;
                    end
                end else if (dec[c] && !i_credit_ret[c]) begin
                    credit[c] <= credit[c] - 1'b1;
                end
            end
        end
    end

    // Pack the credit counters onto the flat output bus.
    always_comb begin
        o_credit = '0;
        for (int c = 0; c < 4; c++) begin
            o_credit[c*CNT_W +: CNT_W] = credit[c];
        end
    end

`ifdef CB_LINE_STATS_EN
    logic [15:0] pkt_cnt [4];
    logic [15:0] stall_cnt;

    // Statistics: wrapping per-column SOP counts, saturating stall count;
    // clear wins over a coincident increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < 4; c++) begin
                pkt_cnt[c] <= '0;
            end
            stall_cnt <= '0;
        end else if (i_stats_clr) begin
            for (int c = 0; c < 4; c++) begin
                pkt_cnt[c] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (accept && i_sop && (hdr_col == 2'(c))) begin
                    pkt_cnt[c] <= pkt_cnt[c] + 16'd1;
                end
            end
            if (i_valid && !o_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Pack the packet counters onto the flat output bus.
    always_comb begin
        o_pkt_cnt = '0;
        for (int c = 0; c < 4; c++) begin
            o_pkt_cnt[c*16 +: 16] = pkt_cnt[c];
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_crossbar_line_credit_ctrl.sv
// Self-checking bench for crossbar_line_credit_ctrl: a directed vector table,
// hand-written multi-cycle sequences, and randomized traffic, all checked
// against a behavioural model of the line (credit array, packet flag, held
// column).

module tb_crossbar_line_credit_ctrl;

    localparam int DATA_W     = 32;
    localparam int NODE_DEPTH = 16;
    localparam int CNT_W      = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0]  din = '0;
    logic               valid = 1'b0;
    logic               sop = 1'b0;
    logic               eop = 1'b0;
    logic [3:0]         credit_ret = '0;
    logic               ready;
    logic [DATA_W-1:0]  cb_din;
    logic [1:0]         cb_sel;
    logic               cb_wr_en;
    logic [4*CNT_W-1:0] credit;
    logic               proto_err;
    logic               credit_err;
    logic               state;
`ifdef CB_LINE_STATS_EN
    logic               stats_clr = 1'b0;
    logic [4*16-1:0]    pkt_cnt;
    logic [15:0]        stall_cnt;
`endif

    crossbar_line_credit_ctrl #(
        .DATA_W(DATA_W), .NODE_DEPTH(NODE_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef CB_LINE_STATS_EN
        .i_stats_clr(stats_clr),
        .o_pkt_cnt(pkt_cnt),
        .o_stall_cnt(stall_cnt),
`endif
        .i_din(din),
        .i_valid(valid),
        .i_sop(sop),
        .i_eop(eop),
        .o_ready(ready),
        .o_cb_din(cb_din),
        .o_cb_sel(cb_sel),
        .o_cb_wr_en(cb_wr_en),
        .i_credit_ret(credit_ret),
        .o_credit(credit),
        .o_proto_err(proto_err),
        .o_credit_err(credit_err),
        .o_state(state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    logic last_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cr(input int c);
        return credit[c*CNT_W +: CNT_W];
    endfunction

    // ---------------- reference model ----------------
    int          m_cr [4];
    bit          m_in_pkt;
    int          m_col;
    logic [31:0] m_din;
    int          m_sel;
    bit          m_wr;
    bit          m_perr;
    bit          m_cerr;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) m_cr[c] = NODE_DEPTH;
        m_in_pkt = 0; m_col = 0; m_din = '0; m_sel = 0;
        m_wr = 0; m_perr = 0; m_cerr = 0;
    endtask

    function automatic bit model_ready(input bit v, input bit s, input logic [31:0] d);
        if (v && s) return m_cr[d[3:2]] > 0;
        if (m_in_pkt) return m_cr[m_col] > 0;
        return 1'b1;
    endfunction

    task automatic model_update(input bit v, input bit s, input bit e,
                                input logic [31:0] d, input logic [3:0] r, input bit rdy);
        int used [4];
        for (int c = 0; c < 4; c++) used[c] = 0;
        m_wr = 0;
        m_perr = 0;
        if (v && rdy) begin
            if (s) begin
                if (m_in_pkt) m_perr = 1;
                m_col = d[3:2];
                m_wr = 1;
                m_in_pkt = !e;
            end else if (m_in_pkt) begin
                m_wr = 1;
                if (e) m_in_pkt = 0;
            end else begin
                m_perr = 1;
            end
        end
        if (m_wr) begin
            m_din = d;
            m_sel = m_col;
            used[m_col] = 1;
        end
        for (int c = 0; c < 4; c++) begin
            int n;
            n = m_cr[c] - used[c] + (r[c] ? 1 : 0);
            if (n > NODE_DEPTH) begin
                n = NODE_DEPTH;
                m_cerr = 1;
            end
            m_cr[c] = n;
        end
    endtask

    task automatic check_model();
        check("wr_en", cb_wr_en, m_wr);
        check("din", cb_din, m_din);
        check("sel", cb_sel, m_sel);
        check("proto_err", proto_err, m_perr);
        check("credit_err", credit_err, m_cerr);
        check("state", state, m_in_pkt);
        for (int c = 0; c < 4; c++) check($sformatf("credit%0d", c), cr(c), m_cr[c]);
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit v, input bit s, input bit e,
                        input logic [31:0] d, input logic [3:0] r);
        bit exp_rdy;
        @(negedge clk);
        valid = v; sop = s; eop = e; din = d; credit_ret = r;
        #1;
        last_rdy = ready;
        exp_rdy = model_ready(v, s, d);
        if (v) check("ready", ready, exp_rdy);
        model_update(v, s, e, d, r, exp_rdy);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        valid = 0; sop = 0; eop = 0; din = '0; credit_ret = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v, s, e;
        logic [31:0] d;
        logic [3:0]  r;
        logic        x_rdy, x_wr, x_perr, x_cerr, x_st;
        logic [1:0]  x_sel;
        logic [1:0]  ccol;
        int          x_cr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // fields: v s e din ret | rdy wr perr cerr state sel | col credit
        tbl[0]  = '{1, 1, 0, 32'h0000000D, 4'h0, 1, 1, 0, 0, 1, 2'd3, 2'd3, 15};
        tbl[1]  = '{1, 0, 0, 32'h11111111, 4'h0, 1, 1, 0, 0, 1, 2'd3, 2'd3, 14};
        tbl[2]  = '{1, 0, 1, 32'h22222222, 4'h0, 1, 1, 0, 0, 0, 2'd3, 2'd3, 13};
        tbl[3]  = '{0, 0, 0, 32'h00000000, 4'h0, 1, 0, 0, 0, 0, 2'd3, 2'd3, 13};
        tbl[4]  = '{1, 0, 0, 32'h00000005, 4'h0, 1, 0, 1, 0, 0, 2'd3, 2'd3, 13};
        tbl[5]  = '{0, 0, 0, 32'h00000000, 4'h8, 1, 0, 0, 0, 0, 2'd3, 2'd3, 14};
        tbl[6]  = '{1, 1, 1, 32'h00000004, 4'h0, 1, 1, 0, 0, 0, 2'd1, 2'd1, 15};
        tbl[7]  = '{1, 1, 0, 32'h00000001, 4'h0, 1, 1, 0, 0, 1, 2'd0, 2'd0, 15};
        tbl[8]  = '{1, 1, 0, 32'hABCD0008, 4'h0, 1, 1, 1, 0, 1, 2'd2, 2'd2, 15};
        tbl[9]  = '{1, 0, 1, 32'h00000033, 4'h4, 1, 1, 0, 0, 0, 2'd2, 2'd2, 15};
        tbl[10] = '{0, 0, 0, 32'h00000000, 4'h1, 1, 0, 0, 0, 0, 2'd2, 2'd0, 16};
        tbl[11] = '{0, 0, 0, 32'h00000000, 4'h1, 1, 0, 0, 1, 0, 2'd2, 2'd0, 16};
        tbl[12] = '{0, 0, 0, 32'h00000000, 4'h0, 1, 0, 0, 1, 0, 2'd2, 2'd0, 16};
    end

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        idle_inputs();
        do_reset();
        #1;
        check("rst_wr_en", cb_wr_en, 1'b0);
        check("rst_din", cb_din, 32'h0);
        check("rst_sel", cb_sel, 2'd0);
        check("rst_perr", proto_err, 1'b0);
        check("rst_cerr", credit_err, 1'b0);
        check("rst_state", state, 1'b0);
        for (int c = 0; c < 4; c++) check($sformatf("rst_credit%0d", c), cr(c), NODE_DEPTH);

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].r);
            if (tbl[i].v) check($sformatf("tbl%0d_ready", i), last_rdy, tbl[i].x_rdy);
            check($sformatf("tbl%0d_wr", i), cb_wr_en, tbl[i].x_wr);
            check($sformatf("tbl%0d_sel", i), cb_sel, tbl[i].x_sel);
            check($sformatf("tbl%0d_perr", i), proto_err, tbl[i].x_perr);
            check($sformatf("tbl%0d_cerr", i), credit_err, tbl[i].x_cerr);
            check($sformatf("tbl%0d_state", i), state, tbl[i].x_st);
            check($sformatf("tbl%0d_credit", i), cr(tbl[i].ccol), tbl[i].x_cr);
            if (tbl[i].x_wr) check($sformatf("tbl%0d_din", i), cb_din, tbl[i].d);
        end

        // 17-word packet to column 1: stall on word 17 until a return.
        do_reset();
        step(1, 1, 0, 32'h00000004, 4'h0);
        for (int i = 1; i < 16; i++) step(1, 0, 0, 32'h100 + i, 4'h0);
        check("stall_credit_zero", cr(1), 0);
        step(1, 0, 1, 32'h00000117, 4'h0);
        check("stall_w17_not_ready", last_rdy, 1'b0);
        check("stall_no_wr", cb_wr_en, 1'b0);
        step(1, 0, 1, 32'h00000117, 4'h2);
        check("stall_ret_cycle_not_ready", last_rdy, 1'b0);
        check("stall_ret_credit", cr(1), 1);
        step(1, 0, 1, 32'h00000117, 4'h0);
        check("stall_w17_ready", last_rdy, 1'b1);
        check("stall_w17_wr", cb_wr_en, 1'b1);
        check("stall_w17_din", cb_din, 32'h117);
        check("stall_final_credit", cr(1), 0);
        check("stall_final_state", state, 1'b0);

        // Write and return to column 2 in the same cycle at credit 5.
        do_reset();
        step(1, 1, 0, 32'h00000008, 4'h0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h200 + i, 4'h0);
        check("same_cycle_pre", cr(2), 5);
        step(1, 0, 1, 32'h0000020F, 4'h4);
        check("same_cycle_wr", cb_wr_en, 1'b1);
        check("same_cycle_credit", cr(2), 5);

        // Asynchronous reset mid-packet with credit[1]=3.
        do_reset();
        step(1, 1, 0, 32'h00000004, 4'h0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 32'h300 + i, 4'h0);
        check("mid_rst_pre_credit", cr(1), 3);
        @(negedge clk);
        valid = 1; sop = 0; eop = 0; din = 32'h3FF; credit_ret = '0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        for (int c = 0; c < 4; c++) check($sformatf("mid_rst_credit%0d", c), cr(c), NODE_DEPTH);
        check("mid_rst_wr_en", cb_wr_en, 1'b0);
        check("mid_rst_state", state, 1'b0);
        check("mid_rst_cerr", credit_err, 1'b0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step(1, 1, 1, 32'h00000004, 4'h0);
        check("post_rst_wr", cb_wr_en, 1'b1);
        check("post_rst_sel", cb_sel, 2'd1);
        check("post_rst_credit", cr(1), 15);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            for (int c = 0; c < 4; c++) r[c] = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
